// File: rtl/srio_dma_sched_pkg.sv
// Shared FSM state type, split-logic register bit positions and completion codes
// for the SRIO DMA split scheduler.
package srio_dma_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    CPL
  } state_e;

  localparam int CMD_EN_BIT    = 0;
  localparam int CMD_SRST_BIT  = 1;
  localparam int STAT_BUSY_BIT = 0;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_ABORT = 2'd1;
  localparam logic [1:0] ERR_TMO   = 2'd2;

  // Packet counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/srio_dma_split_sched_if.sv
// Descriptor, split-logic control, monitor tap and completion signals of the scheduler.
// slave = scheduler side, master = descriptor engine / split logic / completion sink.
interface srio_dma_split_sched_if #(
  parameter int unsigned TAG_W = 8
) ();

  logic             desc_valid;
  logic             desc_ready;
  logic [31:0]      desc_num_pkts;
  logic [31:0]      desc_tuser;
  logic [TAG_W-1:0] desc_tag;
  logic             abort;
  logic [31:0]      cmd;
  logic [31:0]      num_pkts;
  logic [31:0]      tuser_last;
  logic [31:0]      status;
  logic             mon_tvalid;
  logic             mon_tready;
  logic             mon_tlast;
  logic             cpl_valid;
  logic             cpl_ready;
  logic [TAG_W-1:0] cpl_tag;
  logic [31:0]      cpl_pkts;
  logic [1:0]       cpl_err;
  logic             irq;

  modport slave (
    input  desc_valid, desc_num_pkts, desc_tuser, desc_tag, abort, status,
           mon_tvalid, mon_tready, mon_tlast, cpl_ready,
    output desc_ready, cmd, num_pkts, tuser_last, cpl_valid, cpl_tag, cpl_pkts,
           cpl_err, irq
  );

  modport master (
    output desc_valid, desc_num_pkts, desc_tuser, desc_tag, abort, status,
           mon_tvalid, mon_tready, mon_tlast, cpl_ready,
    input  desc_ready, cmd, num_pkts, tuser_last, cpl_valid, cpl_tag, cpl_pkts,
           cpl_err, irq
  );

endinterface

// File: rtl/srio_dma_sched_fifo.sv
// Synchronous show-ahead FIFO holding queued split descriptors; a push while full is
// accepted only when a pop happens in the same cycle.
module srio_dma_sched_fifo #(
  parameter int unsigned WIDTH = 72,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop    = pop_i & ~empty_o;
  assign do_push   = push_i & (~full_o | do_pop);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: storage has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/srio_dma_split_sched.sv
// Descriptor-driven sequencer for the SRIO DMA split logic: runs one queued job at a
// time and posts a completion. Define SRIO_DMA_SCHED_TIMEOUT_EN to add the watchdog.
module srio_dma_split_sched
  import srio_dma_sched_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = 8,
  parameter int unsigned TMO_CYCLES = 1000000
) (
  input logic                    AXIS_ACLK,
  input logic                    AXIS_ARESETN,
  srio_dma_split_sched_if.slave  bus
);

  localparam int unsigned DW = 64 + TAG_W;

  state_e           state_q, state_d;
  logic             srst_q, srst_d;
  logic             irq_q, irq_d;
  logic [1:0]       err_q, err_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [31:0]      num_q, num_d;
  logic [31:0]      tuser_q, tuser_d;
  logic [31:0]      cnt_q, cnt_d;

  logic             desc_ready;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DW-1:0]    fifo_rd;
  logic [TAG_W-1:0] head_tag;
  logic [31:0]      head_tuser, head_num;
  logic             active, counted, tmo, stop_req;
  logic [1:0]       stop_err;
  logic [31:0]      cmd;
  logic             unused_status;

  assign desc_ready = AXIS_ARESETN & ~fifo_full;
  assign fifo_push  = bus.desc_valid & desc_ready;
  assign fifo_pop   = (state_q == LOAD);
  assign {head_tag, head_tuser, head_num} = fifo_rd;

  srio_dma_sched_fifo #(
    .WIDTH (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (AXIS_ACLK),
    .rst_n     (AXIS_ARESETN),
    .push_i    (fifo_push),
    .wr_data_i ({bus.desc_tag, bus.desc_tuser, bus.desc_num_pkts}),
    .pop_i     (fifo_pop),
    .rd_data_o (fifo_rd),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  // The soft-reset cycle (srst_q) still sits in RUN/DRAIN but neither counts nor re-aborts.
  assign active        = ((state_q == RUN) || (state_q == DRAIN)) && !srst_q;
  assign counted       = active && (state_q == RUN) &&
                         bus.mon_tvalid && bus.mon_tready && bus.mon_tlast;
  assign unused_status = ^bus.status[31:1];

`ifdef SRIO_DMA_SCHED_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TMO_CYCLES - 1);

  logic [31:0] wdog_q, wdog_d;

  assign tmo = active && !counted && (wdog_q == TMO_LAST);

  always_comb begin
    wdog_d = wdog_q;
    if ((state_q == LOAD) || counted) wdog_d = '0;
    else if (active)                  wdog_d = wdog_q + 32'd1;
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) wdog_q <= '0;
    else               wdog_q <= wdog_d;
  end
`else
  assign tmo = 1'b0;
`endif

  assign stop_req = bus.abort | tmo;
  assign stop_err = bus.abort ? ERR_ABORT : ERR_TMO;

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    srst_d  = 1'b0;
    irq_d   = 1'b0;
    err_d   = err_q;
    tag_d   = tag_q;
    num_d   = num_q;
    tuser_d = tuser_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: if (!fifo_empty) state_d = LOAD;
      LOAD: begin
        tag_d   = head_tag;
        num_d   = head_num;
        tuser_d = head_tuser;
        cnt_d   = '0;
        err_d   = ERR_OK;
        if (head_num == 32'd0) begin
          state_d = CPL;
          irq_d   = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      RUN, DRAIN: begin
        if (srst_q) begin
          state_d = CPL;
          irq_d   = 1'b1;
        end else begin
          if (counted) cnt_d = sat_inc32(cnt_q);
          if (stop_req) begin
            srst_d = 1'b1;
            err_d  = stop_err;
          end else if (counted && (cnt_d == num_q)) begin
            state_d = DRAIN;
          end else if ((state_q == DRAIN) && !bus.status[STAT_BUSY_BIT]) begin
            state_d = CPL;
            irq_d   = 1'b1;
          end
        end
      end
      CPL:     if (bus.cpl_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) begin
      state_q <= IDLE;
      srst_q  <= 1'b0;
      irq_q   <= 1'b0;
      err_q   <= ERR_OK;
      tag_q   <= '0;
      num_q   <= '0;
      tuser_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      srst_q  <= srst_d;
      irq_q   <= irq_d;
      err_q   <= err_d;
      tag_q   <= tag_d;
      num_q   <= num_d;
      tuser_q <= tuser_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    cmd = '0;
    if (srst_q)                                   cmd[CMD_SRST_BIT] = 1'b1;
    else if ((state_q == RUN) || (state_q == DRAIN)) cmd[CMD_EN_BIT] = 1'b1;
  end

  assign bus.desc_ready = desc_ready;
  assign bus.cmd        = cmd;
  assign bus.num_pkts   = num_q;
  assign bus.tuser_last = tuser_q;
  assign bus.cpl_valid  = (state_q == CPL);
  assign bus.cpl_tag    = tag_q;
  assign bus.cpl_pkts   = cnt_q;
  assign bus.cpl_err    = err_q;
  assign bus.irq        = irq_q;

endmodule

// File: tb/tb_srio_dma_split_sched.sv
// Directed self-checking bench for srio_dma_split_sched: single job, queue fill, zero-packet
// job, abort, completion back-pressure, watchdog (or its absence) and reset mid-job.
module tb_srio_dma_split_sched;

  localparam int unsigned TAG_W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  int unsigned irq_cnt  = 0;
  int unsigned irq_base = 0;

  srio_dma_split_sched_if #(.TAG_W(TAG_W)) bus ();

  srio_dma_split_sched #(
    .FIFO_DEPTH (4),
    .TAG_W      (TAG_W),
    .TMO_CYCLES (16)
  ) dut (
    .AXIS_ACLK    (clk),
    .AXIS_ARESETN (rst_n),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && bus.irq) irq_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic v);
    bus.mon_tvalid = v;
    bus.mon_tready = v;
    bus.mon_tlast  = v;
  endtask

  task automatic push(input logic [31:0] n, input logic [31:0] tu, input logic [7:0] tg);
    check("push ready", bus.desc_ready, 1'b1);
    bus.desc_valid    = 1'b1;
    bus.desc_num_pkts = n;
    bus.desc_tuser    = tu;
    bus.desc_tag      = tg;
    tick();
    bus.desc_valid    = 1'b0;
  endtask

  task automatic wait_en(input string tag);
    int i = 0;
    while (bus.cmd[0] !== 1'b1 && i < 50) begin
      tick();
      i++;
    end
    check({tag, " enable seen"}, bus.cmd[0], 1'b1);
  endtask

  task automatic wait_cpl(input string tag);
    int i = 0;
    while (bus.cpl_valid !== 1'b1 && i < 50) begin
      tick();
      i++;
    end
    check({tag, " cpl seen"}, bus.cpl_valid, 1'b1);
  endtask

  task automatic accept();
    bus.cpl_ready = 1'b1;
    tick();
    bus.cpl_ready = 1'b0;
  endtask

  task automatic serve(input int npk, input logic [7:0] tg);
    bus.status = 32'h1;
    wait_en("serve");
    set_beat(1'b1);
    repeat (npk) tick();
    set_beat(1'b0);
    bus.status = 32'h0;
    wait_cpl("serve");
    check("serve tag", bus.cpl_tag, tg);
    check("serve pkts", bus.cpl_pkts, 64'(npk));
    check("serve err", bus.cpl_err, 2'd0);
    accept();
  endtask

  initial begin
    bus.desc_valid    = 1'b0;
    bus.desc_num_pkts = '0;
    bus.desc_tuser    = '0;
    bus.desc_tag      = '0;
    bus.abort         = 1'b0;
    bus.status        = '0;
    bus.cpl_ready     = 1'b0;
    set_beat(1'b0);

    // Reset values
    repeat (3) tick();
    check("rst cmd", bus.cmd, 32'h0);
    check("rst cpl_valid", bus.cpl_valid, 1'b0);
    check("rst desc_ready held", bus.desc_ready, 1'b0);
    rst_n = 1'b1;
    tick();
    check("rst desc_ready", bus.desc_ready, 1'b1);
    check("rst num_pkts", bus.num_pkts, 32'h0);
    check("rst irq", bus.irq, 1'b0);

    // Abort while idle is ignored
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    tick();
    check("idle abort cmd", bus.cmd, 32'h0);
    check("idle abort cpl", bus.cpl_valid, 1'b0);

    // Single job {3, 0xA5, 7}
    push(32'd3, 32'hA5, 8'd7);
    check("j1 cmd idle", bus.cmd, 32'h0);
    tick();
    check("j1 cmd load", bus.cmd, 32'h0);
    bus.status = 32'h1;
    tick();
    check("j1 cmd run", bus.cmd, 32'h1);
    check("j1 num_pkts", bus.num_pkts, 32'd3);
    check("j1 tuser_last", bus.tuser_last, 32'hA5);
    set_beat(1'b1);
    repeat (3) tick();
    set_beat(1'b0);
    check("j1 cmd drain", bus.cmd, 32'h1);
    tick();
    check("j1 cmd drain2", bus.cmd, 32'h1);
    bus.status = 32'h0;
    tick();
    check("j1 cpl_valid", bus.cpl_valid, 1'b1);
    check("j1 cpl_tag", bus.cpl_tag, 8'd7);
    check("j1 cpl_pkts", bus.cpl_pkts, 32'd3);
    check("j1 cpl_err", bus.cpl_err, 2'd0);
    check("j1 irq", bus.irq, 1'b1);
    check("j1 cmd cpl", bus.cmd, 32'h0);
    accept();
    check("j1 cpl done", bus.cpl_valid, 1'b0);
    check("j1 irq once", irq_cnt, 32'd1);
    check("j1 num_pkts hold", bus.num_pkts, 32'd3);
    check("j1 tuser hold", bus.tuser_last, 32'hA5);

    // Queue fill: one running job plus four held, sixth offer dropped
    irq_base   = irq_cnt;
    bus.status = 32'h1;
    for (int i = 1; i <= 5; i++) push(32'(i), 32'h100 + 32'(i), 8'(i));
    check("q full ready", bus.desc_ready, 1'b0);
    bus.desc_valid    = 1'b1;
    bus.desc_num_pkts = 32'd1;
    bus.desc_tag      = 8'd6;
    repeat (2) tick();
    check("q full ready2", bus.desc_ready, 1'b0);
    bus.desc_valid = 1'b0;
    for (int i = 1; i <= 5; i++) serve(i, 8'(i));
    repeat (4) tick();
    check("q drop cmd", bus.cmd, 32'h0);
    check("q drop cpl", bus.cpl_valid, 1'b0);
    check("q ready again", bus.desc_ready, 1'b1);
    check("q irq count", irq_cnt, 32'(irq_base + 5));

    // Zero-packet descriptor
    bus.status = 32'h0;
    push(32'd0, 32'h55, 8'd9);
    check("z cmd 1", bus.cmd, 32'h0);
    tick();
    check("z cmd 2", bus.cmd, 32'h0);
    tick();
    check("z cmd 3", bus.cmd, 32'h0);
    check("z cpl_valid", bus.cpl_valid, 1'b1);
    check("z cpl_tag", bus.cpl_tag, 8'd9);
    check("z cpl_pkts", bus.cpl_pkts, 32'd0);
    check("z cpl_err", bus.cpl_err, 2'd0);
    check("z num_pkts", bus.num_pkts, 32'd0);
    accept();

    // Abort after 1 of 4 packets, next job still runs
    push(32'd4, 32'h11, 8'h11);
    push(32'd2, 32'h12, 8'h12);
    bus.status = 32'h1;
    wait_en("ab");
    set_beat(1'b1);
    tick();
    set_beat(1'b0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("ab cmd srst", bus.cmd, 32'h2);
    tick();
    check("ab cmd cpl", bus.cmd, 32'h0);
    check("ab cpl_valid", bus.cpl_valid, 1'b1);
    check("ab cpl_tag", bus.cpl_tag, 8'h11);
    check("ab cpl_pkts", bus.cpl_pkts, 32'd1);
    check("ab cpl_err", bus.cpl_err, 2'd1);
    accept();
    serve(2, 8'h12);

    // Completion back-pressure for 10 cycles; abort and beats in CPL ignored
    irq_base = irq_cnt;
    push(32'd1, 32'h21, 8'h21);
    push(32'd3, 32'h22, 8'h22);
    bus.status = 32'h1;
    wait_en("bp");
    set_beat(1'b1);
    tick();
    set_beat(1'b0);
    bus.status = 32'h0;
    wait_cpl("bp");
    for (int i = 0; i < 10; i++) begin
      check("bp cpl_valid", bus.cpl_valid, 1'b1);
      check("bp cpl_tag", bus.cpl_tag, 8'h21);
      check("bp cpl_pkts", bus.cpl_pkts, 32'd1);
      check("bp cpl_err", bus.cpl_err, 2'd0);
      check("bp cmd", bus.cmd, 32'h0);
      check("bp num_pkts", bus.num_pkts, 32'd1);
      bus.abort = (i == 3);
      set_beat(i == 5);
      tick();
    end
    bus.abort = 1'b0;
    set_beat(1'b0);
    check("bp irq single", irq_cnt, 32'(irq_base + 1));
    accept();
    serve(3, 8'h22);

`ifdef SRIO_DMA_SCHED_TIMEOUT_EN
    // Watchdog fires on the 16th beat-less RUN cycle
    push(32'd5, 32'h31, 8'h31);
    bus.status = 32'h1;
    wait_en("tmo");
    repeat (15) tick();
    check("tmo cmd before", bus.cmd, 32'h1);
    tick();
    check("tmo cmd srst", bus.cmd, 32'h2);
    tick();
    check("tmo cpl_valid", bus.cpl_valid, 1'b1);
    check("tmo cpl_tag", bus.cpl_tag, 8'h31);
    check("tmo cpl_pkts", bus.cpl_pkts, 32'd0);
    check("tmo cpl_err", bus.cpl_err, 2'd2);
    accept();
`else
    // No watchdog: a stalled job stays in RUN until aborted
    push(32'd5, 32'h31, 8'h31);
    bus.status = 32'h1;
    wait_en("stall");
    repeat (40) tick();
    check("stall cmd", bus.cmd, 32'h1);
    check("stall cpl", bus.cpl_valid, 1'b0);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("stall cmd srst", bus.cmd, 32'h2);
    tick();
    check("stall cpl_valid", bus.cpl_valid, 1'b1);
    check("stall cpl_err", bus.cpl_err, 2'd1);
    accept();
`endif

    // Reset mid-job loses running and queued jobs
    push(32'd2, 32'h41, 8'h41);
    push(32'd2, 32'h42, 8'h42);
    bus.status = 32'h1;
    wait_en("mr");
    rst_n = 1'b0;
    tick();
    check("mr cmd", bus.cmd, 32'h0);
    check("mr cpl", bus.cpl_valid, 1'b0);
    check("mr num_pkts", bus.num_pkts, 32'h0);
    rst_n = 1'b1;
    repeat (5) tick();
    check("mr idle cmd", bus.cmd, 32'h0);
    check("mr idle cpl", bus.cpl_valid, 1'b0);
    check("mr ready", bus.desc_ready, 1'b1);
    push(32'd1, 32'h50, 8'h50);
    serve(1, 8'h50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
